// File: rtl/awg_index_loader_if.sv
// awg_index_loader_if: sequencer handshake plus AWG serial preset lines
interface awg_index_loader_if #(parameter int INDEX_W = 19);
    logic               start;
    logic [INDEX_W-1:0] index;
    logic [1:0]         frame_en;
    logic               busy;
    logic               done;
    logic               sclk;
    logic               sdata;
    logic               load;
    modport master (output start, index, frame_en, input busy, done, sclk, sdata, load);
    modport slave  (input start, index, frame_en, output busy, done, sclk, sdata, load);
endinterface

// File: rtl/awg_index_loader.sv
// awg_index_loader: self-timed serialiser of a sequencer index into the AWG preset port
module awg_index_loader #(
    parameter int INDEX_W = 19,
    parameter int HI_W    = 6,
    parameter int CLK_DIV = 4
) (
    input logic               clk,
    input logic               rst_n,
    awg_index_loader_if.slave bus
);
    localparam int LO_W = INDEX_W - HI_W;
    localparam int SW   = (HI_W > LO_W ? HI_W : LO_W) + 1;
    localparam int BW   = $clog2(SW);
    localparam int DW   = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SHIFT = 3'd1;
    localparam logic [2:0] LOAD  = 3'd2;
    localparam logic [2:0] GAP   = 3'd3;
    localparam logic [2:0] FIN   = 3'd4;
    logic [2:0]         state;
    logic [DW-1:0]      div_cnt;
    logic               phase;
    logic [BW-1:0]      bit_cnt;
    logic [SW-1:0]      shreg;
    logic               hi_q;
    logic               lo_q;
    logic [INDEX_W-1:0] idx_q;
    logic               div_last;
    logic               bit_last;
    // Frame word left-aligned so the Data_Select bit always leaves from the MSB
    function automatic logic [SW-1:0] frame_word(input logic [INDEX_W-1:0] v, input logic hi);
        frame_word = hi ? SW'({1'b1, v[INDEX_W-1 -: HI_W]}) << (SW - 1 - HI_W)
                        : SW'({1'b0, v[LO_W-1:0]}) << (SW - 1 - LO_W);
    endfunction
    assign div_last  = div_cnt == DW'(CLK_DIV - 1);
    assign bit_last  = bit_cnt == (hi_q ? BW'(HI_W) : BW'(LO_W));
    assign bus.busy  = state == SHIFT || state == LOAD || state == GAP;
    assign bus.done  = state == FIN;
    assign bus.sclk  = state == SHIFT && phase;
    assign bus.load  = state == LOAD;
    assign bus.sdata = (state == SHIFT || state == LOAD) && shreg[SW-1];
    // Sequencer: divider paces every half-period; bits shift out after each sclk high half
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            div_cnt <= '0;
            phase   <= 1'b0;
            bit_cnt <= '0;
            shreg   <= '0;
            hi_q    <= 1'b0;
            lo_q    <= 1'b0;
            idx_q   <= '0;
        end else begin
            div_cnt <= (bus.busy && !div_last) ? div_cnt + 1'b1 : '0;
            case (state)
                IDLE: if (bus.start && |bus.frame_en) begin
                    idx_q   <= bus.index;
                    hi_q    <= bus.frame_en[1];
                    lo_q    <= bus.frame_en[0];
                    shreg   <= frame_word(bus.index, bus.frame_en[1]);
                    bit_cnt <= '0;
                    phase   <= 1'b0;
                    state   <= SHIFT;
                end
                SHIFT: if (div_last) begin
                    phase <= ~phase;
                    if (phase && bit_last) state <= LOAD;
                    else if (phase) begin
                        shreg   <= shreg << 1;
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                LOAD: if (div_last) state <= GAP;
                GAP: if (div_last) begin
                    if (hi_q && lo_q) begin
                        hi_q    <= 1'b0;
                        shreg   <= frame_word(idx_q, 1'b0);
                        bit_cnt <= '0;
                        state   <= SHIFT;
                    end else state <= FIN;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_awg_index_loader.sv
// tb_awg_index_loader: scoreboard bench for the AWG index serialiser
module tb_awg_index_loader;
    localparam int INDEX_W = 19;
    localparam int HI_W    = 6;
    localparam int LO_W    = INDEX_W - HI_W;
    localparam int CLK_DIV = 2;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;
    int rel = 0;
    int sclk_rises, load_rises, load_cyc, busy_cyc, first_busy, last_busy, done_cnt, done_at;
    logic sclk_q = 1'b0;
    logic load_q = 1'b0;
    logic exp_q[$];
    awg_index_loader_if #(.INDEX_W(INDEX_W)) bus ();
    awg_index_loader #(.INDEX_W(INDEX_W), .HI_W(HI_W), .CLK_DIV(CLK_DIV)) u_dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );
    always #5 clk = ~clk;
    always @(posedge clk) rel <= rel + 1;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic push_frames(input logic [INDEX_W-1:0] v, input logic [1:0] fen);
        if (fen[1]) begin
            exp_q.push_back(1'b1);
            for (int i = 0; i < HI_W; i++) exp_q.push_back(v[INDEX_W-1-i]);
        end
        if (fen[0]) begin
            exp_q.push_back(1'b0);
            for (int i = 0; i < LO_W; i++) exp_q.push_back(v[LO_W-1-i]);
        end
    endtask
    task automatic clear_stats();
        sclk_rises = 0; load_rises = 0; load_cyc = 0; busy_cyc = 0;
        first_busy = 0; last_busy = 0; done_cnt = 0; done_at = 0;
    endtask
    task automatic go(input logic [INDEX_W-1:0] v, input logic [1:0] fen);
        @(negedge clk);
        bus.index = v;
        bus.frame_en = fen;
        bus.start = 1'b1;
        if (fen != 2'b00) push_frames(v, fen);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        rel = 1;
        clear_stats();
    endtask
    task automatic wait_done();
        int n;
        n = 0;
        while (done_cnt == 0 && n < 400) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (done_cnt == 0) check("done_timeout", 0, 1);
        repeat (4) @(negedge clk);
        #1;
    endtask
    // Monitor: pop an expected bit on every sclk rise and collect framing statistics
    always @(negedge clk) begin
        if (bus.sclk && !sclk_q) begin
            sclk_rises++;
            if (exp_q.size() == 0) check("extra_bit", 1, 0);
            else check("bit", 32'(bus.sdata), 32'(exp_q.pop_front()));
        end
        if (bus.load && !load_q) load_rises++;
        if (bus.load) load_cyc++;
        if (bus.busy) begin
            if (first_busy == 0) first_busy = rel;
            last_busy = rel;
            busy_cyc++;
        end
        if (bus.done) begin
            done_cnt++;
            done_at = rel;
        end
        sclk_q = bus.sclk;
        load_q = bus.load;
    end
    initial begin
        bus.start = 1'b0;
        bus.index = '0;
        bus.frame_en = 2'b00;
        clear_stats();
        repeat (3) @(negedge clk);
        check("rst_outputs", {27'd0, bus.busy, bus.done, bus.sclk, bus.sdata, bus.load}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        go(19'h5A5A5, 2'b11);
        wait_done();
        check("both_first_busy", first_busy, 1);
        check("both_last_busy", last_busy, 92);
        check("both_busy_cyc", busy_cyc, 92);
        check("both_done_at", done_at, 93);
        check("both_done_cnt", done_cnt, 1);
        check("both_sclk", sclk_rises, 21);
        check("both_loads", load_rises, 2);
        check("both_load_cyc", load_cyc, 4);
        check("both_q_empty", exp_q.size(), 0);
        go(19'h5A5A5, 2'b10);
        wait_done();
        check("hi_sclk", sclk_rises, 7);
        check("hi_loads", load_rises, 1);
        check("hi_busy_cyc", busy_cyc, 32);
        check("hi_done_at", done_at, 33);
        check("hi_q_empty", exp_q.size(), 0);
        go(19'h5A5A5, 2'b01);
        wait_done();
        check("lo_sclk", sclk_rises, 14);
        check("lo_loads", load_rises, 1);
        check("lo_busy_cyc", busy_cyc, 60);
        check("lo_done_at", done_at, 61);
        check("lo_q_empty", exp_q.size(), 0);
        go(19'h2C3D1, 2'b11);
        repeat (20) @(negedge clk);
        bus.index = 19'h7FFFF;
        bus.frame_en = 2'b10;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (30) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done();
        check("mid_busy_cyc", busy_cyc, 92);
        check("mid_done_cnt", done_cnt, 1);
        check("mid_sclk", sclk_rises, 21);
        check("mid_q_empty", exp_q.size(), 0);
        go(19'h12345, 2'b00);
        repeat (20) @(negedge clk);
        #1;
        check("none_busy", busy_cyc, 0);
        check("none_done", done_cnt, 0);
        check("none_sclk", sclk_rises, 0);
        check("none_load", load_rises, 0);
        go(19'h5A5A5, 2'b11);
        repeat (50) @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_outputs", {28'd0, bus.busy, bus.sclk, bus.sdata, bus.load}, 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        #1;
        check("arst_no_done", done_cnt, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("arst_idle", {30'd0, bus.busy, bus.done}, 0);
        go(19'h00001, 2'b01);
        wait_done();
        check("post_sclk", sclk_rises, 14);
        check("post_busy_cyc", busy_cyc, 60);
        check("post_done_cnt", done_cnt, 1);
        check("post_q_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/awg_index_loader.md
Name: awg_index_loader

Overview:
- Serialises a parametrised-width AWG sequencer index into the AWG's serial preset interface.
- Replaces the free-running bit-select multiplexer plus external shift control with a self-timed FSM.
- Generates its own serial clock, Data_Select framing and Load strobes.
- Sends a high frame (Data_Select=1 plus upper index bits) and/or a low frame (Data_Select=0 plus lower index bits), with a start/busy/done handshake toward the sequencer control logic.

Parameters:
- INDEX_W, 19: total sequencer index width.
- HI_W, 6: bits in the high frame, index[INDEX_W-1 : INDEX_W-HI_W]. LO_W = INDEX_W-HI_W (default 13). Legal range 1..INDEX_W-1.
- CLK_DIV, 4: clk cycles per sclk half-period. Must be >= 1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- index  in  INDEX_W  sequencer index; latched when start is accepted.
- frame_en  in  2  [1]=send high frame, [0]=send low frame; latched with index.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse when the transfer completes.
- sclk  out  1  serial clock to the AWG; AWG samples on the rising edge.
- sdata  out  1  serial data, MSB first.
- load  out  1  latch strobe to the AWG.

Behaviour:
- Clock and reset: one clock domain, clk. rst_n is asynchronous, active-low. While rst_n=0, busy, done, sclk, sdata and load are all 0, and the FSM is in IDLE.
- Reset mid-transfer: outputs drop to 0 immediately, the transfer is abandoned with no done pulse, and the next transfer needs a fresh start after release.
- States: IDLE, SHIFT, LOAD, GAP, FIN.
- IDLE:
  - start=1 with frame_en!=0: latch index and frame_en, select the first frame (high if frame_en[1], else low), go to SHIFT.
  - start=1 with frame_en=0: ignored; busy stays 0 and done is not pulsed.
- Frame bit sequence: Data_Select bit first (1 for high frame, 0 for low frame), then the frame field MSB first.
  - High frame: HI_W+1 bits.
  - Low frame: LO_W+1 bits.
- SHIFT, per bit: sdata holds the bit for 2*CLK_DIV cycles. sclk=0 for the first CLK_DIV cycles and 1 for the next CLK_DIV. sdata changes only while sclk=0 (first cycle of each bit). After the last bit, go to LOAD.
- LOAD: sclk=0 and load=1 for CLK_DIV cycles; sdata holds the last bit. Then go to GAP.
- GAP: all serial outputs 0 for CLK_DIV cycles.
  - If the high frame just finished and frame_en[0]=1, go to SHIFT for the low frame.
  - Otherwise go to FIN.
- FIN: one cycle with done=1 and busy=0, then IDLE. A start in the cycle after FIN is accepted.
- busy: 1 from the cycle after start is accepted through the last GAP cycle.
- Latency: first sdata bit appears in the cycle after start.
- Cycle counts with CLK_DIV=D:
  - High frame: (HI_W+1)*2D + 2D cycles.
  - Low frame: (LO_W+1)*2D + 2D cycles.
- During a transfer, start and input changes are ignored; the latched index is used throughout.
- Counters:
  - Divider counter: 0..CLK_DIV-1, wraps.
  - Bit counter: sized for max(HI_W,LO_W)+1; no overflow is possible for legal parameters.

Test Plan:
- Defaults with CLK_DIV=2, index=19'h5A5A5, frame_en=2'b11, start pulsed at edge 0:
  - High-frame bits 1,1,0,1,1,0,1, then one load pulse 2 cycles wide.
  - Low-frame bits 0,0,0,1,0,1,1,0,1,0,0,1,0,1, then a second load pulse.
  - busy high for cycles 1..92, done=1 at cycle 93 only.
- Same index, frame_en=2'b10: exactly 7 sclk rising edges and 1 load pulse; busy for 32 cycles, then done.
- Same index, frame_en=2'b01: 14 bits starting with Data_Select=0, 1 load pulse; busy for 60 cycles.
- Change index and pulse start mid-transfer: serial stream matches the originally latched value, with no restart.
- start with frame_en=2'b00: busy and done stay 0, and sclk/load show no activity.
- Assert rst_n=0 during the low frame: busy, sclk, sdata and load go 0 asynchronously with no done; after release, a new start with index=19'h00001 and frame_en=2'b01 sends 0, then twelve 0s, then a final 1.
